// File: rtl/wb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : wb_lsu
// Brief    : Load/store unit acting as a single-beat classic Wishbone master.
//            Decodes byte/half/word requests into a byte select, runs one
//            bus cycle with error/timeout handling and returns extended load
//            data.
// Revision : 1.0  initial release
// ============================================================================
module wb_lsu #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [XLEN-1:0]       addr_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [XLEN-1:0]       wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [XLEN-1:0]       rdata_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [XLEN-1:0]       wb_dat_o,
    input  logic [XLEN-1:0]       wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    // Counter wide enough to reach TIMEOUT; a disabled timeout still needs one bit.
    localparam int            CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  r_we;
    logic [1:0]            r_addr_lo;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic [XLEN-1:0]       r_wdata;
    logic [XLEN-1:0]       r_rdata;
    logic [CW-1:0]         r_cnt;

    logic                  w_misaligned;
    logic [3:0]            w_sel;
    logic                  w_tmo;
    logic [XLEN-1:0]       w_shifted;
    logic [XLEN-1:0]       w_ext;

    // Request decode: alignment check and byte-lane select.
    always_comb begin
        w_misaligned = 1'b0;
        w_sel        = 4'b1111;
        case (size_i)
            2'b00: w_sel = 4'b0001 << addr_i[1:0];
            2'b01: begin
                w_sel        = addr_i[1] ? 4'b1100 : 4'b0011;
                w_misaligned = addr_i[0];
            end
            2'b10: w_misaligned = (addr_i[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    // Load data alignment and sign/zero extension from the registered request.
    always_comb begin
        w_shifted = wb_dat_i >> {r_addr_lo, 3'b000};
        case (r_size)
            2'b00:   w_ext = {{(XLEN-8){~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_ext = {{(XLEN-16){~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    assign w_tmo = (TIMEOUT != 0) && (r_cnt == C_TMO);

    // Next-state and error-flag logic; err outranks ack, ack outranks timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_state_nxt = w_misaligned ? S_RESP : S_BUS;
                    w_err_nxt   = w_misaligned;
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b1;
                end else if (wb_ack_i) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b0;
                end else if (w_tmo) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and error-flag registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Request capture, wait counter and load-data register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_we       <= 1'b0;
            r_addr_lo  <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_adr      <= '0;
            r_sel      <= 4'b0000;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            if (r_state == S_IDLE && req_i) begin
                r_we       <= we_i;
                r_addr_lo  <= addr_i[1:0];
                r_size     <= size_i;
                r_unsigned <= unsigned_i;
                r_adr      <= addr_i[ADDR_WIDTH+1:2];
                r_sel      <= w_sel;
                r_wdata    <= wdata_i;
                r_cnt      <= '0;
            end else if (r_state == S_BUS && !w_tmo) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_BUS && wb_ack_i && !wb_err_i && !r_we) begin
                r_rdata <= w_ext;
            end
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = (r_state == S_RESP);
    assign err_o    = (r_state == S_RESP) & r_err;
    assign rdata_o  = r_rdata;
    assign wb_cyc_o = (r_state == S_BUS);
    assign wb_stb_o = (r_state == S_BUS);
    assign wb_we_o  = (r_state == S_BUS) & r_we;
    assign wb_adr_o = r_adr;
    assign wb_sel_o = r_sel;
    assign wb_dat_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_lsu
// Brief    : Randomised scoreboard bench for wb_lsu with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        req_i, we_i, unsigned_i;
    logic [31:0] addr_i, wdata_i;
    logic [1:0]  size_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    wb_lsu #(.XLEN(32), .ADDR_WIDTH(30), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rdata_o(rdata_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference load result: select the addressed bytes, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] data, input int off,
                                             input int size, input logic uns);
        longint v;
        int     nbits;
        nbits = 8 << size;
        v = longint'(data) >> (8 * off);
        if (size < 2) begin
            v = v % (longint'(1) << nbits);
            if (!uns && v >= (longint'(1) << (nbits - 1)))
                v = v - (longint'(1) << nbits);
        end
        return v[31:0];
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n_i && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("done_resp", {err_o, rdata_o}, e);
            end
        end
    end

    // kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout); w = wait cycles.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd, input logic [31:0] bd,
                          input int kind, input int w, input logic hold);
        logic       mis, exp_err;
        logic [3:0] sel;
        int         exp_done, exp_cyc, cyc_n, done_c;
        logic       seen;
        mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        sel = (size == 2'b00) ? (4'b0001 << addr[1:0]) :
              (size == 2'b01) ? (4'b0011 << addr[1:0]) : 4'b1111;
        exp_err = mis || kind != 0;
        if (!exp_err && !we) m_rdata = ref_load(bd, int'(addr[1:0]), int'(size), uns);
        exp_q.push_back({exp_err, m_rdata});
        exp_cyc  = mis ? 0 : (kind == 3) ? TMO + 1 : w + 1;
        exp_done = exp_cyc + 1;

        req_i = 1'b1; we_i = we; addr_i = addr; size_i = size;
        unsigned_i = uns; wdata_i = wd; wb_dat_i = bd;
        @(posedge clk); #1;
        if (!hold) req_i = 1'b0;
        cyc_n = 0; done_c = 0; seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            wb_ack_i = (kind == 0 || kind == 2) && (c == w + 1);
            wb_err_i = (kind == 1 || kind == 2) && (c == w + 1);
            @(negedge clk);
            if (wb_cyc_o) begin
                cyc_n++;
                if (!seen) begin
                    seen = 1'b1;
                    check("bus_fields", {wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
                          {1'b1, we, sel, addr[31:2], wd});
                end
            end
            if (done_o) begin
                done_c = c;
                break;
            end
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("done_cycle", done_c, exp_done);
        check("cyc_cycles", cyc_n, exp_cyc);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; size_i = '0;
        unsigned_i = 1'b0; wdata_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy_o, done_o, err_o, rdata_o, wb_cyc_o, wb_stb_o, wb_we_o,
                                wb_adr_o, wb_sel_o, wb_dat_o}, 0);
        @(negedge clk) rst_n_i = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_txn(1'b1, 32'h1000_0008, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, 3, 1'b0);
        do_txn(1'b0, 32'h2000_0003, 2'b00, 1'b0, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b0);
        do_txn(1'b0, 32'h2000_0003, 2'b00, 1'b1, 32'h0, 32'h80FF_FF7F, 0, 1, 1'b0);
        do_txn(1'b0, 32'h3000_0002, 2'b01, 1'b0, 32'h0, 32'h8001_1234, 0, 2, 1'b0);
        do_txn(1'b0, 32'h3000_0001, 2'b10, 1'b0, 32'h0, 32'h1111_1111, 3, 0, 1'b0);
        do_txn(1'b0, 32'h3000_0000, 2'b11, 1'b0, 32'h0, 32'h2222_2222, 3, 0, 1'b0);
        do_txn(1'b0, 32'h4000_0000, 2'b10, 1'b0, 32'h0, 32'h3333_3333, 2, 1, 1'b0);
        do_txn(1'b0, 32'h4000_0004, 2'b10, 1'b0, 32'h0, 32'h4444_4444, 3, 0, 1'b0);
        do_txn(1'b0, 32'h4000_0008, 2'b10, 1'b0, 32'h0, 32'h5555_5555, 0, TMO, 1'b0);

        // Back-to-back with req_i held high throughout the first transfer.
        do_txn(1'b0, 32'h5000_0001, 2'b00, 1'b1, 32'h0, 32'hAABB_CCDD, 0, 2, 1'b1);
        do_txn(1'b0, 32'h5000_0001, 2'b00, 1'b1, 32'h0, 32'hAABB_CCDD, 0, 1, 1'b0);

        // Reset asserted mid-BUS aborts the transfer silently.
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h6000_0000; size_i = 2'b10; wb_dat_i = 32'h1234_5678;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        check("cyc_before_reset", wb_cyc_o, 1'b1);
        #2 rst_n_i = 1'b0;
        #1;
        check("reset_abort", {busy_o, done_o, err_o, rdata_o, wb_cyc_o, wb_stb_o, wb_we_o,
                              wb_adr_o, wb_sel_o, wb_dat_o}, 0);
        m_rdata = '0;
        @(negedge clk) rst_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          k, wt;
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            k  = $urandom_range(0, 5);
            if (k > 3) k = 0;
            wt = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
            if (wt == TMO) k = 0;
            do_txn(1'($urandom), a, sz, 1'($urandom), $urandom, $urandom, k, wt, 1'b0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
